// File: rtl/pool_pkg.sv
// pool_pkg: shared constants, FSM encoding and window slot helper for the pooling path
package pool_pkg;
    localparam int DWIDTH   = 8;
    localparam int KSIZE    = 3;
    localparam int WIN_BITS = KSIZE * KSIZE * DWIDTH;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LAST, S_PRESENT, S_DONE} state_t;

    function automatic int win_slot(input int r, input int c);
        return (r * KSIZE + c) * DWIDTH;
    endfunction
endpackage

// File: rtl/pool_addr_gen.sv
// pool_addr_gen: window position and read-index counters, BRAM address and last-window flag
module pool_addr_gen
    import pool_pkg::*;
#(
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8,
    parameter int STRIDE    = 1,
    parameter int AWIDTH    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_step,
    input  logic              i_advance,
    output logic [7:0]        o_x,
    output logic [7:0]        o_y,
    output logic [1:0]        o_row,
    output logic [1:0]        o_col,
    output logic              o_k_last,
    output logic              o_last_win,
    output logic [AWIDTH-1:0] o_addr
);
    localparam int AW = AWIDTH + 8;

    logic [7:0] r_x, r_y;
    logic [1:0] r_row, r_col;
    logic       w_x_more, w_y_more;

    assign w_x_more   = int'(r_x) + STRIDE <= IMG_W - KSIZE;
    assign w_y_more   = int'(r_y) + STRIDE <= IMG_H - KSIZE;
    assign o_last_win = !w_x_more && !w_y_more;
    assign o_k_last   = (r_row == 2'(KSIZE - 1)) && (r_col == 2'(KSIZE - 1));
    assign o_addr     = AWIDTH'(AW'(BASE_ADDR) + (AW'(r_y) + AW'(r_row)) * AW'(IMG_W) + AW'(r_x) + AW'(r_col));
    assign o_x        = r_x;
    assign o_y        = r_y;
    assign o_row      = r_row;
    assign o_col      = r_col;

    // read index walks the 3x3 footprint; position steps row-major on each accepted window
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_x   <= '0;
            r_y   <= '0;
            r_row <= '0;
            r_col <= '0;
        end else begin
            if (i_step) begin
                r_col <= (r_col == 2'(KSIZE - 1)) ? 2'd0 : r_col + 2'd1;
                if (r_col == 2'(KSIZE - 1))
                    r_row <= (r_row == 2'(KSIZE - 1)) ? 2'd0 : r_row + 2'd1;
            end
            if (i_advance && w_x_more) begin
                r_x <= r_x + 8'(STRIDE);
            end else if (i_advance && w_y_more) begin
                r_x <= '0;
                r_y <= r_y + 8'(STRIDE);
            end
        end
    end
endmodule

// File: rtl/pool_window_fetch.sv
// pool_window_fetch: reads 3x3 windows from BRAM row-major and hands each out via valid/ready
module pool_window_fetch #(
    parameter int DWIDTH    = 8,
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8,
    parameter int STRIDE    = 1,
    parameter int AWIDTH    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    output logic                o_bram_en,
    output logic [AWIDTH-1:0]   o_bram_addr,
    input  logic [DWIDTH-1:0]   i_bram_rdata,
    output logic [9*DWIDTH-1:0] o_win_data,
    output logic                o_win_valid,
    input  logic                i_win_ready,
    output logic [7:0]          o_win_x,
    output logic [7:0]          o_win_y,
    output logic                o_busy,
    output logic                o_done
);
    import pool_pkg::*;

    if (IMG_W < 3) begin : g_bad_w
        $error("IMG_W must be >= 3");
    end
    if (IMG_H < 3) begin : g_bad_h
        $error("IMG_H must be >= 3");
    end
    if (STRIDE < 1) begin : g_bad_s
        $error("STRIDE must be >= 1");
    end
    if (IMG_W * IMG_H > 2 ** AWIDTH) begin : g_bad_a
        $error("image does not fit in the BRAM address space");
    end
    if (DWIDTH != pool_pkg::DWIDTH) begin : g_bad_d
        $error("DWIDTH must match the shared pooling pixel width");
    end

    state_t              r_state, w_next;
    logic [WIN_BITS-1:0] r_win;
    logic                r_cap_en;
    logic [1:0]          r_cap_row, r_cap_col;
    logic                w_fetch, w_hs, w_clear, w_k_last, w_last_win;
    logic [1:0]          w_row, w_col;
    logic [AWIDTH-1:0]   w_addr;

    pool_addr_gen #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .STRIDE(STRIDE), .AWIDTH(AWIDTH), .BASE_ADDR(BASE_ADDR)
    ) u_addr (
        .clk(clk), .rst_n(rst_n), .i_clear(w_clear), .i_step(w_fetch), .i_advance(w_hs),
        .o_x(o_win_x), .o_y(o_win_y), .o_row(w_row), .o_col(w_col),
        .o_k_last(w_k_last), .o_last_win(w_last_win), .o_addr(w_addr)
    );

    assign o_win_data = r_win;

    // state register; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        r_state <= !rst_n ? S_IDLE : w_next;
    end

    // next-state: nine reads, one capture cycle, present until accepted
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = i_start ? S_FETCH : S_IDLE;
            S_FETCH:   w_next = w_k_last ? S_LAST : S_FETCH;
            S_LAST:    w_next = S_PRESENT;
            S_PRESENT: w_next = !i_win_ready ? S_PRESENT : (w_last_win ? S_DONE : S_FETCH);
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // outputs decoded from state; address forced to zero when not reading
    always_comb begin
        w_fetch     = r_state == S_FETCH;
        w_clear     = (r_state == S_IDLE) && i_start;
        o_win_valid = r_state == S_PRESENT;
        o_busy      = r_state != S_IDLE;
        o_done      = r_state == S_DONE;
        w_hs        = o_win_valid && i_win_ready;
        o_bram_en   = w_fetch;
        o_bram_addr = w_fetch ? w_addr : '0;
    end

    // slot k is written on the edge after read k; clearing r_cap_en on reset drops a late return
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cap_en  <= 1'b0;
            r_cap_row <= '0;
            r_cap_col <= '0;
            r_win     <= '0;
        end else begin
            r_cap_en  <= w_fetch;
            r_cap_row <= w_row;
            r_cap_col <= w_col;
            if (r_cap_en)
                r_win[win_slot(int'(r_cap_row), int'(r_cap_col)) +: DWIDTH] <= i_bram_rdata;
        end
    end
endmodule
